// File: rtl/mem_responder.sv
// mem_responder: single-port word RAM that answers the core's memory handshake.
// Each request gets a fixed response latency of LATENCY cycles. The RAM commits
// a write, or registers read data, on the clock edge that enters RESP, so an
// aborted or reset request never touches the RAM.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic        mem_resp,
    output logic [31:0] mem_rdata,
    output logic        busy,
    output logic        protocol_err
);

    localparam int IDX = $clog2(DEPTH_WORDS);
    // Initial countdown for BUSY. It is unused when LATENCY == 1, because
    // that case goes straight from IDLE to RESP.
    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             op_write_q, op_write_d;
    logic [IDX-1:0]   idx_q, idx_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q;

    // Signals for the operation that commits on this edge
    // (the edge entering RESP).
    logic             commit_rd;
    logic             commit_wr;
    logic [IDX-1:0]   commit_idx;
    logic [31:0]      commit_wdata;
    logic [3:0]       commit_be;
    logic [3:0]       lane_we;

    logic             req;
    logic [IDX-1:0]   addr_idx;
    logic             unused_addr_bits;

    logic [31:0]      ram [DEPTH_WORDS];

    assign req      = mem_read | mem_write;
    // Address bits above the RAM size are dropped, so addresses alias.
    assign addr_idx = mem_address[IDX+1:2];
    assign unused_addr_bits = ^{mem_address[31:IDX+2], mem_address[1:0]};

    // Next-state logic: accept, count down, abort or respond, and pick the
    // fields to commit.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_write_d   = op_write_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        err_d        = err_q;
        commit_rd    = 1'b0;
        commit_wr    = 1'b0;
        commit_idx   = idx_q;
        commit_wdata = wdata_q;
        commit_be    = be_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    // A simultaneous read and write runs as a write
                    // and is flagged.
                    op_write_d = mem_write;
                    idx_d      = addr_idx;
                    wdata_d    = mem_wdata;
                    be_d       = mem_byte_enable;
                    if (mem_read && mem_write) begin
                        err_d = 1'b1;
                    end
                    if (LATENCY == 1) begin
                        // With single-cycle latency the commit uses the
                        // live inputs, because the latched copy is not
                        // valid yet.
                        state_d      = S_RESP;
                        commit_rd    = ~mem_write;
                        commit_wr    = mem_write;
                        commit_idx   = addr_idx;
                        commit_wdata = mem_wdata;
                        commit_be    = mem_byte_enable;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_BUSY: begin
                if (mem_read && mem_write) begin
                    err_d = 1'b1;
                end
                if (!req) begin
                    // Abort: the initiator withdrew, so nothing commits.
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d   = S_RESP;
                    commit_rd = ~op_write_q;
                    commit_wr = op_write_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and latched request fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            op_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_write_q <= op_write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            err_q      <= err_d;
        end
    end

    // Byte-lane write enables. Reset blocks a commit that lands on the same
    // edge as the reset.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane_we
            assign lane_we[gi] = ~rst & commit_wr & commit_be[gi];
        end
    endgenerate

    // RAM write port with per-byte enables.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) begin
                ram[commit_idx][i*8 +: 8] <= commit_wdata[i*8 +: 8];
            end
        end
    end

    // Registered RAM read. The register holds its value until the next
    // read commits.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'd0;
        end else if (commit_rd) begin
            rdata_q <= ram[commit_idx];
        end
    end

    assign mem_resp     = (state_q == S_RESP);
    assign busy         = (state_q != S_IDLE);
    assign mem_rdata    = rdata_q;
    assign protocol_err = err_q;

endmodule
